// File: rtl/prog_uart_loader_pkg.sv
// ============================================================================
// Module      : prog_loader_pkg
// Description : Shared constants, defaults and frame-FSM state type for the
//               UART program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam int DEFAULT_CLKS_PER_BIT = 87;
    localparam int DEFAULT_MAX_LEN      = 22;
    localparam int DEFAULT_ADDR_W       = 5;
    localparam int DEFAULT_TIMEOUT_CLKS = 20000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CKSUM = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } frame_state_t;

endpackage

`default_nettype wire

// File: rtl/prog_uart_loader_if.sv
// ============================================================================
// Module      : prog_uart_loader_if
// Description : Instruction-memory write port driven by the program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface prog_uart_loader_if #(
    parameter int ADDR_W = 5
);
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [7:0]        mem_data_o;

    modport master (output mem_we_o, output mem_addr_o, output mem_data_o);
    modport slave  (input  mem_we_o, input  mem_addr_o, input  mem_data_o);
endinterface

`default_nettype wire

// File: rtl/prog_uart_loader_uart_rx_byte.sv
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 UART receiver with input synchroniser; pulses byte_valid
//               on a good stop bit and fe on a bad one.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 87
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       rx_i,
    output logic            byte_valid,
    output logic [7:0]      rx_byte,
    output logic            fe
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_full_last = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_half_last = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    rx_state_t        r_state;
    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_prev;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= RX_IDLE;
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            fe         <= 1'b0;
        end else begin
            r_rx_meta  <= rx_i;
            r_rx_sync  <= r_rx_meta;
            r_rx_prev  <= r_rx_sync;
            byte_valid <= 1'b0;
            fe         <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    r_cnt <= '0;
                    r_bit <= '0;
                    if (r_rx_prev && !r_rx_sync)
                        r_state <= RX_START;
                end
                RX_START: begin
                    // A line that is high again at mid start bit was only a glitch
                    if (r_cnt == c_half_last) begin
                        r_cnt   <= '0;
                        r_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == c_full_last) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        if (r_bit == 3'd7)
                            r_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == c_full_last) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
                        if (r_rx_sync) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= r_shift;
                        end else begin
                            fe <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/prog_uart_loader.sv
// ============================================================================
// Module      : prog_uart_loader
// Description : Loads a framed program image from UART into instruction
//               memory and releases the core once the image is complete.
//               Macro PROG_CKSUM_EN adds the trailing XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_uart_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int MAX_LEN      = DEFAULT_MAX_LEN,
    parameter int ADDR_W       = DEFAULT_ADDR_W,
    parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              rx_i,
    prog_uart_loader_if.master     mem,
    output logic                   cpu_run_o,
    output logic                   busy_o,
    output logic                   err_o
);
    localparam int TMO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]       c_max_len  = 8'(MAX_LEN);

    logic       w_byte_valid;
    logic [7:0] w_rx_byte;
    logic       w_fe;
    logic       w_last;
    logic       w_abort;

    frame_state_t      r_state;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_data;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [TMO_W-1:0]  r_tmo;
`ifdef PROG_CKSUM_EN
    logic [7:0]        r_cksum;
`endif

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_i       (rx_i),
        .byte_valid (w_byte_valid),
        .rx_byte    (w_rx_byte),
        .fe         (w_fe)
    );

    assign busy_o = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CKSUM);
    assign w_last = ({{(8-ADDR_W){1'b0}}, r_addr} == (r_len - 8'd1));
    // A byte arriving on the expiry cycle wins over the timeout
    assign w_abort = busy_o && !w_byte_valid && (w_fe || (r_tmo == c_tmo_last));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_addr     <= '0;
            r_len      <= '0;
            r_tmo      <= '0;
            cpu_run_o  <= 1'b0;
            err_o      <= 1'b0;
`ifdef PROG_CKSUM_EN
            r_cksum    <= '0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            r_tmo    <= (busy_o && !w_byte_valid) ? r_tmo + TMO_W'(1) : '0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (w_byte_valid && (w_rx_byte == SYNC_BYTE)) begin
                        r_state   <= ST_LEN;
                        err_o     <= 1'b0;
                        cpu_run_o <= 1'b0;
                        r_addr    <= '0;
`ifdef PROG_CKSUM_EN
                        r_cksum   <= '0;
`endif
                    end
                end
                ST_LEN: begin
                    if (w_byte_valid) begin
                        if ((w_rx_byte == 8'd0) || (w_rx_byte > c_max_len)) begin
                            r_state <= ST_ERR;
                            err_o   <= 1'b1;
                        end else begin
                            r_len   <= w_rx_byte;
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_byte_valid) begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_mem_data <= w_rx_byte;
                        r_addr     <= r_addr + ADDR_W'(1);
`ifdef PROG_CKSUM_EN
                        r_cksum    <= r_cksum ^ w_rx_byte;
                        if (w_last)
                            r_state <= ST_CKSUM;
`else
                        if (w_last) begin
                            r_state   <= ST_DONE;
                            cpu_run_o <= 1'b1;
                        end
`endif
                    end
                end
`ifdef PROG_CKSUM_EN
                ST_CKSUM: begin
                    if (w_byte_valid) begin
                        if (w_rx_byte == r_cksum) begin
                            r_state   <= ST_DONE;
                            cpu_run_o <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            err_o   <= 1'b1;
                        end
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
            if (w_abort) begin
                r_state   <= ST_ERR;
                err_o     <= 1'b1;
                cpu_run_o <= 1'b0;
            end
        end
    end

    assign mem.mem_we_o   = r_mem_we;
    assign mem.mem_addr_o = r_mem_addr;
    assign mem.mem_data_o = r_mem_data;

endmodule

`default_nettype wire

// File: tb/tb_prog_uart_loader.sv
// ============================================================================
// Module      : tb_prog_uart_loader
// Description : Self-checking bench for prog_uart_loader; frame-level model
//               honours PROG_CKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_uart_loader;
    import prog_loader_pkg::*;

    localparam int CPB     = 16;
    localparam int MAX_LEN = 22;
    localparam int ADDR_W  = 5;
    localparam int TMO     = 1000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;
    logic run, busy, err;

    int checks   = 0;
    int failures = 0;

    logic [12:0] wr_q[$];
    logic [12:0] exp_q[$];
    logic        exp_run, exp_err, exp_tmo;
    logic [7:0]  fr[$];

    prog_uart_loader_if #(.ADDR_W(ADDR_W)) mem_if ();

    prog_uart_loader #(
        .CLKS_PER_BIT (CPB),
        .MAX_LEN      (MAX_LEN),
        .ADDR_W       (ADDR_W),
        .TIMEOUT_CLKS (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_i      (rx),
        .mem       (mem_if),
        .cpu_run_o (run),
        .busy_o    (busy),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && mem_if.mem_we_o)
            wr_q.push_back({mem_if.mem_addr_o, mem_if.mem_data_o});

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        clks(1);
        rx = 1'b0;
        clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            clks(CPB);
        end
        rx = stop_bit;
        clks(CPB);
        rx = 1'b1;
        clks(2 * CPB);
    endtask

    // Frame-level reference: what the image should leave in memory and on the status pins
    task automatic model_frame(input logic [7:0] f[$]);
        int len, n;
        logic [7:0] x;
        exp_q.delete();
        exp_run = 1'b0;
        exp_err = 1'b0;
        exp_tmo = 1'b0;
        len = int'(f[1]);
        if (len == 0 || len > MAX_LEN) begin
            exp_err = 1'b1;
        end else begin
            n = (len < f.size() - 2) ? len : f.size() - 2;
            x = 8'h00;
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({5'(i), f[2+i]});
                x = x ^ f[2+i];
            end
            if (n < len) begin
                exp_err = 1'b1;
                exp_tmo = 1'b1;
            end else begin
`ifdef PROG_CKSUM_EN
                if (f.size() > 2 + len) begin
                    exp_run = (f[2+len] == x);
                    exp_err = !exp_run;
                end else begin
                    exp_err = 1'b1;
                    exp_tmo = 1'b1;
                end
`else
                exp_run = 1'b1;
`endif
            end
        end
    endtask

    task automatic check_writes(input string tag);
        check_val({tag, "_nwr"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
            check_val({tag, "_addr"}, 32'(wr_q[i][12:8]), 32'(exp_q[i][12:8]));
            check_val({tag, "_data"}, 32'(wr_q[i][7:0]), 32'(exp_q[i][7:0]));
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] f[$]);
        model_frame(f);
        wr_q.delete();
        for (int i = 0; i < f.size(); i++) begin
            send_byte(f[i], 1'b1);
            if (i == 0)
                check_val({tag, "_busy_len"}, busy, 1);
        end
        if (exp_tmo) begin
            clks(TMO / 2);
            check_val({tag, "_busy_pre_tmo"}, busy, 1);
            check_val({tag, "_err_pre_tmo"}, err, 0);
            clks(TMO / 2 + 4 * CPB);
        end else begin
            clks(4 * CPB);
        end
        check_writes(tag);
        check_val({tag, "_run"}, run, exp_run);
        check_val({tag, "_err"}, err, exp_err);
        check_val({tag, "_busy"}, busy, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_we"}, mem_if.mem_we_o, 0);
        check_val({tag, "_addr"}, 32'(mem_if.mem_addr_o), 0);
        check_val({tag, "_data"}, 32'(mem_if.mem_data_o), 0);
        check_val({tag, "_run"}, run, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_err"}, err, 0);
    endtask

    initial begin
        int len;
        logic [7:0] x;
        logic run_before;

        clks(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        clks(2 * CPB);

        run_frame("good3",   '{8'hA5, 8'h03, 8'h01, 8'h05, 8'h0A, 8'h0E});
        run_frame("badck",   '{8'hA5, 8'h02, 8'h01, 8'h05, 8'hFF});
        run_frame("good1",   '{8'hA5, 8'h01, 8'h0A, 8'h0A});
        run_frame("len0",    '{8'hA5, 8'h00});
        run_frame("len23",   '{8'hA5, 8'h17});
        run_frame("len22",   '{8'hA5, 8'h16});
        run_frame("timeout", '{8'hA5, 8'h03, 8'h01});

        // Stop bit forced low inside DATA
        wr_q.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h55, 1'b0);
        clks(4 * CPB);
        exp_q.delete();
        exp_q.push_back({5'd0, 8'h01});
        check_writes("fe");
        check_val("fe_err", err, 1);
        check_val("fe_run", run, 0);
        check_val("fe_busy", busy, 0);

        // Reset in the middle of DATA
        wr_q.delete();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        check_val("prerst_nwr", wr_q.size(), 2);
        fork
            send_byte(8'hFF, 1'b1);
            begin
                clks(4 * CPB);
                rst_n = 1'b0;
                clks(2);
                check_idle_outputs("midrst");
                rst_n = 1'b1;
            end
        join
        wr_q.delete();
        clks(20 * CPB);
        check_val("postrst_nwr", wr_q.size(), 0);
        check_idle_outputs("postrst");

        // Short low glitch while idle must not start a byte
        rx = 1'b0;
        clks(CPB / 4);
        rx = 1'b1;
        clks(20 * CPB);
        check_val("glitch_nwr", wr_q.size(), 0);
        check_idle_outputs("glitch");

        run_frame("reload", '{8'hA5, 8'h03, 8'h01, 8'h05, 8'h0A, 8'h0E});

        // Glitch and framing error while DONE leave the core running
        run_before = run;
        rx = 1'b0;
        clks(CPB / 4);
        rx = 1'b1;
        clks(20 * CPB);
        send_byte(8'h3C, 1'b0);
        clks(4 * CPB);
        check_val("done_glitch_run", run, run_before);
        check_val("done_glitch_busy", busy, 0);

        for (int k = 0; k < 5; k++) begin
            len = $urandom_range(1, MAX_LEN);
            fr.delete();
            fr.push_back(SYNC_BYTE);
            fr.push_back(8'(len));
            x = 8'h00;
            for (int i = 0; i < len; i++) begin
                fr.push_back(8'($urandom_range(0, 255)));
                x = x ^ fr[fr.size()-1];
            end
`ifdef PROG_CKSUM_EN
            if ($urandom_range(0, 3) == 0)
                x = x ^ 8'($urandom_range(1, 255));
            fr.push_back(x);
`endif
            run_frame($sformatf("rand%0d", k), fr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/prog_uart_loader.md
Name: prog_uart_loader

Overview:
- Upstream stage of the 8-bit accumulator core.
- Receives a program image over a single UART RX pin.
- Validates the frame and drives the core's instruction-memory write port (we/addr/data), byte by byte.
- Releases the core via cpu_run_o only after a complete, valid image has been written.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per UART bit (10 MHz / 115200).
- MAX_LEN, 22, maximum program bytes; equals instruction memory depth.
- ADDR_W, 5, write-address width.
- TIMEOUT_CLKS, 20000, maximum idle clocks between bytes inside a frame.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_i  in  1  UART RX, 8N1, idle high, asynchronous to clk.
- mem_we_o  out  1  one-cycle write strobe to instruction memory.
- mem_addr_o  out  ADDR_W  write address.
- mem_data_o  out  8  write data.
- cpu_run_o  out  1  high = core may execute; low = core held.
- busy_o  out  1  high while a frame is in progress (LEN..CKSUM).
- err_o  out  1  sticky frame error; cleared on next sync byte.

Behaviour:
- Reset is asynchronous, active-low, on rst_n; clock is clk. Reset values: all outputs 0; FSM = IDLE; counters 0.
- RX synchroniser: 2-flop synchroniser on rx_i, reset value 1.
- Start bit: falling edge, re-checked at CLKS_PER_BIT/2. If the line is high again, treat as a glitch and return to idle.
- Data bits: sampled every CLKS_PER_BIT at mid-bit, LSB first.
- Stop bit: sampled mid-bit. If 0, framing error: byte is dropped and fe pulses for 1 cycle.
- Receiver output: byte_valid pulses 1 cycle with rx_byte.
- Frame FSM states: IDLE, LEN, DATA, CKSUM, DONE, ERR.
  - IDLE: wait for byte 0xA5; other bytes ignored.
  - 0xA5 received in IDLE, DONE or ERR: go to LEN; clear err_o and cpu_run_o; reset address and checksum to 0.
  - LEN: byte of 0 or > MAX_LEN → ERR. Otherwise latch len and go to DATA.
  - DATA: each byte_valid registers mem_data_o = byte and mem_addr_o = addr; mem_we_o is high the following cycle (1-cycle latency).
    - After each write: addr++, checksum ^= byte.
    - Once len bytes are written: go to CKSUM (or DONE, see optional feature).
  - CKSUM: byte equals running XOR → DONE; otherwise → ERR.
  - DONE: cpu_run_o = 1 and stays high.
  - ERR: err_o = 1, cpu_run_o = 0.
- 0xA5 inside LEN/DATA/CKSUM is ordinary data, not a resync.
- Framing error in LEN/DATA/CKSUM → ERR. Framing error in IDLE/DONE is ignored.
- Timeout: counter clears on every byte_valid. Reaching TIMEOUT_CLKS while in LEN/DATA/CKSUM → ERR. If byte_valid arrives in the same cycle the timeout expires, the byte wins.
- Partial image on error: already-written bytes stay in memory; cpu_run_o stays 0.
- Address: never exceeds len-1, so no wrap.
- Reset mid-frame: immediate return to IDLE, no further writes, cpu_run_o = 0.
- busy_o = state ∈ {LEN, DATA, CKSUM}.

Optional Feature:
- Macro: PROG_CKSUM_EN.
- Defined: CKSUM state present. Frame is 0xA5, LEN, data, XOR checksum; mismatch → ERR.
- Undefined: no CKSUM state. DATA goes directly to DONE after the last byte; the checksum register is not built.

Decomposition:
- Package prog_loader_pkg:
  - SYNC_BYTE = 8'hA5.
  - State enum for the frame FSM.
  - Default CLKS_PER_BIT, MAX_LEN, TIMEOUT_CLKS.
- Sub-module uart_rx_byte:
  - Contains the synchroniser, bit timer and shift register.
  - Outputs byte_valid, rx_byte, fe.
- The top holds the frame FSM, address/len/checksum counters and timeout counter.

Test Plan:
- Send A5 03 01 05 0A 0E (checksum = 01^05^0A = 0E) → exactly 3 mem_we_o pulses: addr 0/1/2, data 01/05/0A; then cpu_run_o = 1, err_o = 0.
- Send A5 02 01 05 FF (bad checksum) → 2 writes, then err_o = 1, cpu_run_o = 0. Send A5 01 0A 0A → err_o clears, 1 write, cpu_run_o = 1.
- Send A5 00, then separately A5 17 (23 > MAX_LEN) → each gives err_o = 1 and no writes.
- Send A5 03 01, then hold rx_i high for TIMEOUT_CLKS+10 → err_o = 1 after 1 write; busy_o falls.
- Send a byte with stop bit forced 0 inside DATA → err_o = 1. Send a 20-clk low glitch on rx_i while in IDLE → no byte_valid, state unchanged.
- Assert rst_n low mid-DATA → no writes after reset, all outputs 0. A subsequent full load succeeds.
